// File: rtl/oka_shared_mult_scheduler.sv
// Sequential overlap-free Karatsuba GF(2)[x] multiplier that time-shares one external
// HxH sub-multiplier over the even, odd and mixed sub-products.
module oka_shared_mult_scheduler #(
  parameter int N       = 12,
  parameter int TIMEOUT = 64,
  localparam int H = N / 2,
  localparam int P = N - 1,
  localparam int W = 2 * N - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         mul_req,
  output logic [H-1:0] mul_op_a,
  output logic [H-1:0] mul_op_b,
  input  logic         mul_ack,
  input  logic [P-1:0] mul_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         busy,
  output logic         err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, MUL_EE, MUL_OO, MUL_MM, OUT} state_t;

  state_t        state;
  logic [N-1:0]  a_q, b_q;
  logic [P-1:0]  e_q, o_q;
  logic [CW-1:0] wd_cnt;

  function automatic logic [H-1:0] evens(input logic [N-1:0] v);
    evens = '0;
    for (int i = 0; i < H; i++) evens[i] = v[2*i];
  endfunction

  function automatic logic [H-1:0] odds(input logic [N-1:0] v);
    odds = '0;
    for (int i = 0; i < H; i++) odds[i] = v[2*i+1];
  endfunction

  // ex pads E with a zero top coefficient, ox shifts O up by one so ox[i] = O[i-1]
  function automatic logic [W-1:0] recombine(input logic [P-1:0] e, o, m);
    logic [N-1:0] ex, ox;
    recombine = '0;
    ex = {1'b0, e};
    ox = {o, 1'b0};
    for (int i = 0; i < N; i++) recombine[2*i]   = ex[i] ^ ox[i];
    for (int i = 0; i < P; i++) recombine[2*i+1] = m[i] ^ e[i] ^ o[i];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      mul_req     <= 1'b0;
      mul_op_a    <= '0;
      mul_op_b    <= '0;
      out_valid   <= 1'b0;
      out_prod    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      e_q         <= '0;
      o_q         <= '0;
      wd_cnt      <= '0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= in_a;
          b_q      <= in_b;
          mul_op_a <= evens(in_a);
          mul_op_b <= evens(in_b);
          mul_req  <= 1'b1;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          wd_cnt   <= '0;
          state    <= MUL_EE;
        end
        MUL_EE, MUL_OO, MUL_MM: begin
          if (mul_ack) begin
            wd_cnt <= '0;
            if (state == MUL_EE) begin
              e_q      <= mul_res;
              mul_op_a <= odds(a_q);
              mul_op_b <= odds(b_q);
              state    <= MUL_OO;
            end else if (state == MUL_OO) begin
              o_q      <= mul_res;
              mul_op_a <= evens(a_q) ^ odds(a_q);
              mul_op_b <= evens(b_q) ^ odds(b_q);
              state    <= MUL_MM;
            end else begin
              out_prod  <= recombine(e_q, o_q, mul_res);
              out_valid <= 1'b1;
              mul_req   <= 1'b0;
              mul_op_a  <= '0;
              mul_op_b  <= '0;
              state     <= OUT;
            end
          end else if (TIMEOUT > 0 && wd_cnt == WD_LAST) begin
            // abandon the operation; the consumer never sees a product for it
            err_timeout <= 1'b1;
            mul_req     <= 1'b0;
            mul_op_a    <= '0;
            mul_op_b    <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oka_shared_mult_scheduler.sv
// Directed bench for oka_shared_mult_scheduler: vector table of products and sub-multiplier
// operands, plus hand-written ack-delay, backpressure, watchdog and reset sequences.
module tb_oka_shared_mult_scheduler;
  localparam int N = 12;
  localparam int H = 6;
  localparam int P = 11;
  localparam int W = 23;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [N-1:0] in_a, in_b;
  logic         mul_req, mul_ack;
  logic [H-1:0] mul_op_a, mul_op_b;
  logic [P-1:0] mul_res;
  logic         out_valid, out_ready;
  logic [W-1:0] out_prod;
  logic         busy, err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // sub-multiplier responder controls
  int   ack_delay  = 0;
  int   ack_limit  = 99;
  logic force_ack  = 1'b0;
  int   wait_cnt   = 0;
  int   acks_given = 0;
  int   err_pulses = 0;
  logic [2*H-1:0] opq[$];

  always #5 clk = ~clk;

  oka_shared_mult_scheduler #(.N(N), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_req(mul_req), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_ack(mul_ack), .mul_res(mul_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .busy(busy), .err_timeout(err_timeout)
  );

  function automatic logic [P-1:0] clmul_h(input logic [H-1:0] a, b);
    clmul_h = '0;
    for (int i = 0; i < H; i++) if (b[i]) clmul_h = clmul_h ^ (P'(a) << i);
  endfunction

  assign mul_res = clmul_h(mul_op_a, mul_op_b);
  assign mul_ack = force_ack | (mul_req && (acks_given < ack_limit) && (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    if (rst || !mul_req || mul_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (rst || !mul_req) acks_given <= 0;
    else if (mul_ack) acks_given <= acks_given + 1;
  end

  always @(negedge clk) begin
    if (mul_req && mul_ack) opq.push_back({mul_op_a, mul_op_b});
    if (err_timeout) err_pulses <= err_pulses + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [W-1:0]   prod;
    logic [6*H-1:0] ops;   // {ee_a,ee_b,oo_a,oo_b,mm_a,mm_b}
  } vec_t;

  vec_t vecs[7];

  task automatic do_op(input logic [N-1:0] a, b, input logic [W-1:0] exp_prod,
                       input logic [6*H-1:0] exp_ops, input int exp_lat, input int hold,
                       input string tag);
    int lat;
    int bad;
    logic [W-1:0] p0;
    opq.delete();
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    chk({tag, "_busy"}, {busy, in_ready}, 2'b10);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_prod"}, out_prod, exp_prod);
    chk({tag, "_in_ready_out"}, in_ready, 0);
    p0 = out_prod;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_prod !== p0 || in_ready) bad++;
    end
    if (hold > 0) chk({tag, "_hold"}, bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_after_hs"}, {in_ready, out_valid, busy}, 3'b100);
    chk({tag, "_prod_kept"}, out_prod, exp_prod);
    chk({tag, "_nops"}, opq.size(), 3);
    if (opq.size() == 3) chk({tag, "_ops"}, {opq[0], opq[1], opq[2]}, exp_ops);
  endtask

  initial begin
    int c;
    int pulses, ovs, first;
    logic rdy_at_err, req_at_err;

    vecs[0] = '{12'h001, 12'h001, 23'h000001, {6'h01, 6'h01, 6'h00, 6'h00, 6'h01, 6'h01}};
    vecs[1] = '{12'h003, 12'h003, 23'h000005, {6'h01, 6'h01, 6'h01, 6'h01, 6'h00, 6'h00}};
    vecs[2] = '{12'h800, 12'h800, 23'h400000, {6'h00, 6'h00, 6'h20, 6'h20, 6'h20, 6'h20}};
    vecs[3] = '{12'hFFF, 12'h001, 23'h000FFF, {6'h3F, 6'h01, 6'h3F, 6'h00, 6'h00, 6'h01}};
    vecs[4] = '{12'hFFF, 12'hFFF, 23'h555555, {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00}};
    vecs[5] = '{12'h002, 12'h003, 23'h000006, {6'h00, 6'h01, 6'h01, 6'h01, 6'h01, 6'h00}};
    vecs[6] = '{12'h0A5, 12'h003, 23'h0001EF, {6'h03, 6'h01, 6'h0C, 6'h01, 6'h0F, 6'h00}};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctrl", {in_ready, mul_req, out_valid, busy, err_timeout}, 5'b10000);
    chk("reset_ops", {mul_op_a, mul_op_b}, 0);
    chk("reset_prod", out_prod, 0);

    // zero-latency acks, immediate out_ready
    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].ops, 4, 0, $sformatf("vec%0d", i));

    // acks three cycles late (last legal cycle before the watchdog), 5 cycles backpressure
    ack_delay = 3;
    do_op(vecs[6].a, vecs[6].b, vecs[6].prod, vecs[6].ops, 13, 5, "slow");
    ack_delay = 0;
    chk("no_spurious_timeout", err_pulses, 0);

    // watchdog: no ack ever given in MUL_OO
    ack_limit = 1;
    @(negedge clk);
    in_a = 12'h123; in_b = 12'h456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulses = 0; ovs = 0; first = 0; rdy_at_err = 1'b0; req_at_err = 1'b1;
    for (c = 1; c <= 20; c++) begin
      if (err_timeout) begin
        pulses++;
        if (first == 0) begin
          first = c; rdy_at_err = in_ready; req_at_err = mul_req;
        end
      end
      if (out_valid) ovs++;
      @(posedge clk); #1;
    end
    ack_limit = 99;
    chk("wd_pulses", pulses, 1);
    chk("wd_cycle", first, 6);
    chk("wd_no_out_valid", ovs, 0);
    chk("wd_idle_after", {rdy_at_err, req_at_err}, 2'b10);

    // ack while idle must be ignored
    force_ack = 1'b1;
    c = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (!in_ready || busy || mul_req || out_valid) c++;
    end
    force_ack = 1'b0;
    chk("spurious_ack_idle", c, 0);

    // reset in MUL_MM together with an ack
    ack_delay = 2;
    @(negedge clk);
    in_a = 12'h0A5; in_b = 12'h003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    while (acks_given != 2 && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("reach_mul_mm", acks_given, 2);
    rst = 1'b1; force_ack = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; force_ack = 1'b0;
    ack_delay = 0;
    chk("mid_reset_ctrl", {in_ready, mul_req, out_valid, busy, err_timeout}, 5'b10000);
    chk("mid_reset_data", {mul_op_a, mul_op_b, out_prod}, 0);
    c = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid || busy) c++;
    end
    chk("mid_reset_quiet", c, 0);

    do_op(vecs[1].a, vecs[1].b, vecs[1].prod, vecs[1].ops, 4, 0, "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
